// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pkg
//  Description : Shared types, constants and helpers for the servo motion
//                sequencer (angle type, FSM state encoding, target clamp).
//  Revision    : 1.0 - initial release
// ============================================================================
package servo_pkg;

    localparam int N_CH       = 4;
    localparam int ANGLE_W    = 8;
    localparam int ANGLE_MAX  = 180;
    localparam int HOME_ANGLE = 90;

    typedef logic [ANGLE_W-1:0] angle_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    // Saturate an incoming target to the mechanical limit of the servo.
    function automatic angle_t clamp_angle(input angle_t a);
        return (a > angle_t'(ANGLE_MAX)) ? angle_t'(ANGLE_MAX) : a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : servo_tick_gen
//  Description : Ramp-rate prescaler. Counts 0..TICK_DIV-1 while enabled and
//                pulses o_tick on the wrap cycle. i_clr forces the count to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module servo_tick_gen #(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int              CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_en && !i_clr && (r_cnt == c_LAST);

    // Prescaler counter: clear has priority, holds when not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/servo_motion_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : servo_motion_sequencer
//  Description : Latches a set of servo targets and ramps each commanded angle
//                toward its target by STEP degrees per tick, one channel per
//                clock in a round-robin sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module servo_motion_sequencer
    import servo_pkg::*;
#(
    parameter int STEP     = 1,
    parameter int TICK_DIV = 500000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      tgt_valid,
    output logic                      tgt_ready,
    input  logic [N_CH*ANGLE_W-1:0]   tgt_angle,
    input  logic                      home_req,
    output logic [N_CH*ANGLE_W-1:0]   cmd_angle,
    output logic [N_CH-1:0]           moving,
    output logic                      busy,
    output logic                      done
);

    localparam int               IDX_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] c_LAST_CH = IDX_W'(N_CH - 1);
    localparam angle_t           c_HOME    = angle_t'(HOME_ANGLE);
    localparam angle_t           c_STEP_A  = angle_t'(STEP);
    localparam logic [ANGLE_W:0] c_STEP_W  = (ANGLE_W+1)'(STEP);

    seq_state_t        r_state;
    logic [IDX_W-1:0]  r_ch_idx;
    angle_t            r_cmd [N_CH];
    angle_t            r_tgt [N_CH];
    logic              r_done;

    logic                      w_tick;
    logic                      w_accept;
    angle_t                    w_sel_cmd;
    angle_t                    w_sel_tgt;
    logic signed [ANGLE_W:0]   w_diff;
    logic [ANGLE_W:0]          w_abs;
    angle_t                    w_step_val;
    logic                      w_all_eq;

    servo_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (enable),
        .i_clr  (r_state != WAIT),
        .o_tick (w_tick)
    );

    assign tgt_ready = (r_state != UPDATE) && !home_req;
    assign w_accept  = tgt_valid && tgt_ready;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign cmd_angle[g*ANGLE_W +: ANGLE_W] = r_cmd[g];
        assign moving[g]                       = (r_cmd[g] != r_tgt[g]);
    end

    assign w_sel_cmd = r_cmd[r_ch_idx];
    assign w_sel_tgt = r_tgt[r_ch_idx];

    // Step datapath: move the selected channel by STEP, landing exactly on target.
    always_comb begin
        w_diff = $signed({1'b0, w_sel_tgt}) - $signed({1'b0, w_sel_cmd});
        w_abs  = w_diff[ANGLE_W] ? (ANGLE_W+1)'(-w_diff) : (ANGLE_W+1)'(w_diff);
        if (w_abs <= c_STEP_W) begin
            w_step_val = w_sel_tgt;
        end else if (!w_diff[ANGLE_W]) begin
            w_step_val = w_sel_cmd + c_STEP_A;
        end else begin
            w_step_val = w_sel_cmd - c_STEP_A;
        end
    end

    // Convergence check including the value being written this cycle.
    always_comb begin
        w_all_eq = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (IDX_W'(i) == r_ch_idx) begin
                w_all_eq = w_all_eq && (w_step_val == r_tgt[i]);
            end else begin
                w_all_eq = w_all_eq && (r_cmd[i] == r_tgt[i]);
            end
        end
    end

    // Target registers: home request overrides an offered target set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) r_tgt[i] <= c_HOME;
        end else if (home_req) begin
            for (int i = 0; i < N_CH; i++) r_tgt[i] <= c_HOME;
        end else if (w_accept) begin
            for (int i = 0; i < N_CH; i++) r_tgt[i] <= clamp_angle(tgt_angle[i*ANGLE_W +: ANGLE_W]);
        end
    end

    // Command registers: only the channel under the sweep pointer updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) r_cmd[i] <= c_HOME;
        end else if (r_state == UPDATE) begin
            r_cmd[r_ch_idx] <= w_step_val;
        end
    end

    // Sequencer FSM: idle -> wait for tick -> sweep channels -> done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ch_idx <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|moving) r_state <= WAIT;
                end
                WAIT: begin
                    if (w_tick) begin
                        r_state  <= UPDATE;
                        r_ch_idx <= '0;
                    end
                end
                UPDATE: begin
                    if (r_ch_idx == c_LAST_CH) begin
                        r_ch_idx <= '0;
                        if (w_all_eq) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                        end
                    end else begin
                        r_ch_idx <= r_ch_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_servo_motion_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo_motion_sequencer
//  Description : Self-checking bench for servo_motion_sequencer. A reference
//                ramp model pushes expected command changes to a scoreboard
//                queue; a negedge monitor pops and compares each change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_motion_sequencer;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        tgt_valid = 1'b0;
    logic        home_req = 1'b0;
    logic [31:0] tgt_angle = 32'h5A5A5A5A;
    logic        tgt_ready;
    logic [31:0] cmd_angle;
    logic [3:0]  moving;
    logic        busy;
    logic        done;

    logic        tgt_valid3 = 1'b0;
    logic        home_req3 = 1'b0;
    logic [31:0] tgt_angle3 = 32'h5A5A5A5A;
    logic        tgt_ready3;
    logic [31:0] cmd_angle3;
    logic [3:0]  moving3;
    logic        busy3;
    logic        done3;

    servo_motion_sequencer #(.STEP(1), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .enable(enable), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .tgt_angle(tgt_angle), .home_req(home_req), .cmd_angle(cmd_angle), .moving(moving),
        .busy(busy), .done(done)
    );

    servo_motion_sequencer #(.STEP(3), .TICK_DIV(TD)) dut3 (
        .clk(clk), .rst(rst), .enable(enable), .tgt_valid(tgt_valid3), .tgt_ready(tgt_ready3),
        .tgt_angle(tgt_angle3), .home_req(home_req3), .cmd_angle(cmd_angle3), .moving(moving3),
        .busy(busy3), .done(done3)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int unsigned exp_q[$];
    int          ch0_t[$];
    int          m_cmd[4];
    int          m_tgt[4];
    logic [31:0] prev_cmd;
    bit          mon_en = 1'b0;
    int          done_seen = 0;
    int          cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard monitor: every observed command change must match the model.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < 4; c++) begin
                if (cmd_angle[c*8 +: 8] !== prev_cmd[c*8 +: 8]) begin
                    total = total + 1;
                    if (c == 0) ch0_t.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        bad = bad + 1;
                        $display("FAIL sb_unexpected ch%0d got=%0d expected=no change", c, cmd_angle[c*8 +: 8]);
                    end else begin
                        int unsigned e;
                        e = exp_q.pop_front();
                        if (e !== (c*256 + int'(cmd_angle[c*8 +: 8]))) begin
                            bad = bad + 1;
                            $display("FAIL sb_step got ch%0d=%0d expected ch%0d=%0d", c, cmd_angle[c*8 +: 8], e/256, e%256);
                        end
                    end
                end
            end
            if (done === 1'b1) done_seen = done_seen + 1;
        end
        prev_cmd = cmd_angle;
    end

    function automatic int clampv(input int v);
        return (v > 180) ? 180 : v;
    endfunction

    // Reference ramp: whole sweeps, channels in order, one degree per tick.
    task automatic model_ramp();
        bit any;
        do begin
            any = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (m_cmd[c] != m_tgt[c]) begin
                    any = 1'b1;
                    m_cmd[c] = (m_tgt[c] > m_cmd[c]) ? m_cmd[c] + 1 : m_cmd[c] - 1;
                    exp_q.push_back(c*256 + m_cmd[c]);
                end
            end
        end while (any);
    endtask

    task automatic drive_targets(input logic [31:0] t);
        @(negedge clk);
        tgt_angle = t;
        tgt_valid = 1'b1;
        for (int c = 0; c < 4; c++) m_tgt[c] = clampv(int'(t[c*8 +: 8]));
        model_ramp();
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s_timeout got pending=%0d busy=%0d expected idle", name, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (cmd_angle !== 32'h5A5A5A5A) begin bad++; $display("FAIL rst_cmd got=%h expected=5a5a5a5a", cmd_angle); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b expected=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b expected=0", done); end
        total++; if (tgt_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b expected=1", tgt_ready); end
        total++; if (moving !== 4'b0) begin bad++; $display("FAIL rst_moving got=%b expected=0000", moving); end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin m_cmd[c] = 90; m_tgt[c] = 90; end
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_single_channel();
        int d0;
        d0 = done_seen;
        ch0_t.delete();
        total++; if (tgt_ready !== 1'b1) begin bad++; $display("FAIL t2_ready got=%b expected=1", tgt_ready); end
        drive_targets({8'd90, 8'd90, 8'd90, 8'd100});
        total++; if (moving !== 4'b0001) begin bad++; $display("FAIL t2_moving got=%b expected=0001", moving); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t2_busy got=%b expected=1", busy); end
        wait_quiet(400, "t2");
        total++; if (done_seen - d0 !== 1) begin bad++; $display("FAIL t2_done_count got=%0d expected=1", done_seen - d0); end
        total++; if (ch0_t.size() !== 10) begin bad++; $display("FAIL t2_steps got=%0d expected=10", ch0_t.size()); end
        for (int i = 1; i < ch0_t.size(); i++) begin
            total++;
            if (ch0_t[i] - ch0_t[i-1] !== 4 + TD) begin
                bad++; $display("FAIL t2_interval got=%0d expected=%0d", ch0_t[i] - ch0_t[i-1], 4 + TD);
            end
        end
    endtask

    task automatic test_clamp_mixed();
        int n;
        drive_targets({8'd89, 8'd180, 8'd0, 8'd200});
        n = 0;
        while (cmd_angle[31:24] !== 8'd89 && n < 100) begin @(negedge clk); n++; end
        total++; if (moving[3] !== 1'b0) begin bad++; $display("FAIL t3_moving3 got=%b expected=0", moving[3]); end
        total++; if (moving[1] !== 1'b1) begin bad++; $display("FAIL t3_moving1 got=%b expected=1", moving[1]); end
        wait_quiet(2000, "t3");
        total++; if (cmd_angle !== {8'd89, 8'd180, 8'd0, 8'd180}) begin bad++; $display("FAIL t3_final got=%h expected=59b400b4", cmd_angle); end
    endtask

    task automatic test_home_priority();
        int d0;
        d0 = done_seen;
        @(negedge clk);
        tgt_angle = 32'h0A0A0A0A;
        tgt_valid = 1'b1;
        home_req  = 1'b1;
        #1;
        total++; if (tgt_ready !== 1'b0) begin bad++; $display("FAIL t4_ready got=%b expected=0", tgt_ready); end
        for (int c = 0; c < 4; c++) m_tgt[c] = 90;
        model_ramp();
        @(posedge clk); #1;
        tgt_valid = 1'b0;
        home_req  = 1'b0;
        wait_quiet(2000, "t4");
        total++; if (cmd_angle !== 32'h5A5A5A5A) begin bad++; $display("FAIL t4_final got=%h expected=5a5a5a5a", cmd_angle); end
        total++; if (done_seen - d0 !== 1) begin bad++; $display("FAIL t4_done_count got=%0d expected=1", done_seen - d0); end
    endtask

    task automatic test_enable_freeze();
        int n, d0, q0;
        logic [31:0] snap;
        d0 = done_seen;
        drive_targets({8'd90, 8'd90, 8'd90, 8'd95});
        n = 0;
        while (cmd_angle[7:0] !== 8'd91 && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        enable = 1'b0;
        snap = cmd_angle;
        q0 = exp_q.size();
        repeat (20) @(negedge clk);
        total++; if (cmd_angle !== snap) begin bad++; $display("FAIL t5_frozen got=%h expected=%h", cmd_angle, snap); end
        total++; if (exp_q.size() !== q0) begin bad++; $display("FAIL t5_pending got=%0d expected=%0d", exp_q.size(), q0); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t5_busy got=%b expected=1", busy); end
        enable = 1'b1;
        wait_quiet(400, "t5");
        total++; if (cmd_angle[7:0] !== 8'd95) begin bad++; $display("FAIL t5_final got=%0d expected=95", cmd_angle[7:0]); end
        total++; if (done_seen - d0 !== 1) begin bad++; $display("FAIL t5_done_count got=%0d expected=1", done_seen - d0); end
    endtask

    task automatic test_same_target();
        int d0, b;
        d0 = done_seen;
        b = 0;
        drive_targets(cmd_angle);
        repeat (20) begin @(negedge clk); if (busy === 1'b1) b++; end
        total++; if (b !== 0) begin bad++; $display("FAIL same_busy got=%0d cycles expected=0", b); end
        total++; if (done_seen - d0 !== 0) begin bad++; $display("FAIL same_done got=%0d expected=0", done_seen - d0); end
    endtask

    task automatic test_reset_midrun();
        drive_targets(32'h96969696);
        repeat (30) @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (cmd_angle !== 32'h5A5A5A5A) begin bad++; $display("FAIL t1_cmd got=%h expected=5a5a5a5a", cmd_angle); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy got=%b expected=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL t1_done got=%b expected=0", done); end
        total++; if (tgt_ready !== 1'b1) begin bad++; $display("FAIL t1_ready got=%b expected=1", tgt_ready); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 4; c++) begin m_cmd[c] = 90; m_tgt[c] = 90; end
        repeat (10) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_stays_idle got=%b expected=0", busy); end
        mon_en = 1'b1;
    endtask

    // Step-3 instance: own scoreboard queue, checked as values appear.
    task automatic run3(input logic [31:0] t, input int budget, input string name, output int dn);
        int unsigned q3[$];
        logic [7:0] p;
        int n, v;
        v = int'(cmd_angle3[7:0]);
        while (v != int'(t[7:0])) begin
            if (int'(t[7:0]) > v) v = (int'(t[7:0]) - v <= 3) ? int'(t[7:0]) : v + 3;
            else                  v = (v - int'(t[7:0]) <= 3) ? int'(t[7:0]) : v - 3;
            q3.push_back(v);
        end
        dn = 0;
        p = cmd_angle3[7:0];
        @(negedge clk);
        tgt_angle3 = t;
        tgt_valid3 = 1'b1;
        @(posedge clk); #1;
        tgt_valid3 = 1'b0;
        n = 0;
        while ((q3.size() != 0 || busy3) && n < budget) begin
            @(negedge clk);
            n++;
            if (done3 === 1'b1) dn++;
            if (cmd_angle3[7:0] !== p) begin
                total++;
                if (q3.size() == 0) begin
                    bad++; $display("FAIL %s_unexpected got=%0d expected=no change", name, cmd_angle3[7:0]);
                end else begin
                    v = q3.pop_front();
                    if (int'(cmd_angle3[7:0]) !== v) begin
                        bad++; $display("FAIL %s_step got=%0d expected=%0d", name, cmd_angle3[7:0], v);
                    end
                end
                p = cmd_angle3[7:0];
            end
        end
        total++;
        if (n >= budget) begin
            bad++; $display("FAIL %s_timeout got pending=%0d expected=0", name, q3.size());
        end
    endtask

    task automatic test_step3();
        int dn;
        run3(32'h5A5A5A00, 1000, "t6a", dn);
        total++; if (dn !== 1) begin bad++; $display("FAIL t6a_done_count got=%0d expected=1", dn); end
        run3(32'h5A5A5A05, 200, "t6b", dn);
        total++; if (dn !== 1) begin bad++; $display("FAIL t6b_done_count got=%0d expected=1", dn); end
        total++; if (cmd_angle3[7:0] !== 8'd5) begin bad++; $display("FAIL t6_final got=%0d expected=5", cmd_angle3[7:0]); end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_clamp_mixed();
        test_home_priority();
        test_enable_freeze();
        test_same_target();
        test_reset_midrun();
        test_step3();
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL sb_leftover got=%0d expected=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
